// File: rtl/seg_pkg.sv
// Shared constants and state type for the 4-digit 7-segment scan controller.
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

endpackage

// File: rtl/segment.sv
// BCD-to-7-segment decoder, active-low segments {g,f,e,d,c,b,a}.
module segment
    import seg_pkg::*;
(
    input  logic [3:0] num,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (num)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit common-anode display scanner with per-slot blanking and
// frame-synchronous double buffering. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start,
    output logic        pending
);

    localparam int            CW         = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    idx, idx_next;
    logic          boundary;
    logic [15:0]   shadow, active;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic          digit_off;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          fs_next;

    segment u_segment (
        .num (nibble),
        .seg (dec_seg)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        boundary   = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                    boundary   = 1'b1;
                end
                BLANK: begin
                    cnt_next = cnt + CW'(1);
                    if (cnt == BLANK_LAST) state_next = DRIVE;
                end
                DRIVE: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_next   = '0;
                        idx_next   = idx + 2'd1;
                        state_next = BLANK;
                        boundary   = (idx == 2'd3);
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Invalid nibbles and (optionally) leading zeros override the decoder.
    always_comb begin
        nibble    = active[{idx, 2'b00} +: 4];
        digit_off = (nibble > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            2'd3:    digit_off = digit_off | (active[15:12] == 4'h0);
            2'd2:    digit_off = digit_off | (active[15:8] == 8'h00);
            2'd1:    digit_off = digit_off | (active[15:4] == 12'h000);
            default: digit_off = digit_off;
        endcase
`endif
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        fs_next  = (state == BLANK) && (idx == 2'd0) && (cnt == '0);
        if (state == DRIVE) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = digit_off ? SEG_OFF : dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            an          <= an_next;
            seg         <= seg_next;
            frame_start <= fs_next;
            if (boundary && pending) active <= shadow;
            // A load on the boundary cycle wins over the boundary's clear.
            if (load) begin
                shadow  <= value_in;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int DIGIT_CYCLES = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * DIGIT_CYCLES;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;
    logic        pending;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the frame (-1 = scanning stopped).
    int          m_ph;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    logic        m_pend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_fs;

    seg_scan_ctrl #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .value_in    (value_in),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seven(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        m_ph     = -1;
        m_shadow = '0;
        m_active = '0;
        m_pend   = 1'b0;
        exp_an   = 4'b1111;
        exp_seg  = 7'b1111111;
        exp_fs   = 1'b0;
    endtask

    task automatic model_step();
        int          d;
        int          o;
        logic        bnd;
        logic [3:0]  nib;
        logic        off;
        exp_an  = 4'b1111;
        exp_seg = 7'b1111111;
        exp_fs  = (m_ph == 0);
        if (m_ph >= 0) begin
            d = m_ph / DIGIT_CYCLES;
            o = m_ph % DIGIT_CYCLES;
            if (o >= BLANK_CYCLES) begin
                nib    = m_active[4*d +: 4];
                off    = (nib > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
                if (d > 0 && (m_active >> (4*d)) == 16'h0) off = 1'b1;
`endif
                exp_an  = ~(4'b0001 << d);
                exp_seg = off ? 7'b1111111 : seven(nib);
            end
        end
        bnd = enable && (m_ph < 0 || m_ph == FRAME - 1);
        if (!enable)      m_ph = -1;
        else if (m_ph < 0) m_ph = 0;
        else              m_ph = (m_ph + 1) % FRAME;
        if (bnd && m_pend) m_active = m_shadow;
        if (load) begin
            m_shadow = value_in;
            m_pend   = 1'b1;
        end else if (bnd) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] val);
        enable   = en;
        load     = ld;
        value_in = val;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (an === exp_an) else begin
            failures++;
            $error("[TB] FAIL %s_an observed=%b expected=%b", tag, an, exp_an);
        end
        checks++;
        assert (seg === exp_seg) else begin
            failures++;
            $error("[TB] FAIL %s_seg observed=%b expected=%b", tag, seg, exp_seg);
        end
        checks++;
        assert (frame_start === exp_fs) else begin
            failures++;
            $error("[TB] FAIL %s_frame_start observed=%b expected=%b", tag, frame_start, exp_fs);
        end
        checks++;
        assert (pending === m_pend) else begin
            failures++;
            $error("[TB] FAIL %s_pending observed=%b expected=%b", tag, pending, m_pend);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        checkOutput(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic wait_ph(input int target, input string tag);
        int guard = 0;
        while (m_ph != target && guard < 4 * FRAME) begin
            tick(tag);
            guard++;
        end
        checks++;
        assert (m_ph == target) else begin
            failures++;
            $error("[TB] FAIL %s_timeout observed_ph=%0d expected_ph=%0d", tag, m_ph, target);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        model_reset();
        #12;
        checkOutput("reset");
        #11;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0000);

        run(2 * FRAME + 4, "scan_zero");

        wait_ph(12, "mid_frame");
        applyStimulus(1'b1, 1'b1, 16'h1234);
        tick("load_1234");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        run(2 * FRAME + 2, "show_1234");

        wait_ph(FRAME - 1, "pre_boundary");
        applyStimulus(1'b1, 1'b1, 16'h5678);
        tick("load_on_boundary");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        run(2 * FRAME, "show_5678");

        applyStimulus(1'b1, 1'b1, 16'h00A5);
        tick("load_00a5");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        run(2 * FRAME + 3, "show_00a5");

        wait_ph(2 * DIGIT_CYCLES + 4, "digit2_drive");
        applyStimulus(1'b0, 1'b1, 16'h0987);
        tick("disable");
        applyStimulus(1'b0, 1'b0, 16'h0000);
        run(4, "idle");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        run(FRAME + 4, "reenable");

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
                          16'($urandom));
            tick("random");
        end
        applyStimulus(1'b1, 1'b0, 16'h0000);
        run(FRAME, "random_settle");

        wait_ph(DIGIT_CYCLES + 5, "pre_reset");
        #2;
        rst_n = 1'b0;
        model_reset();
        #2;
        checkOutput("async_reset");
        #3;
        rst_n = 1'b1;
        run(FRAME + 4, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
